// File: rtl/pd_pluse_decoder.sv
// rtl/pd_pluse_decoder.sv - pulse code word decoder: sync, window timestamping, record FIFO.
// Optional PD_DECODE_ERR_EN: reject multi-hot phase codes and count them on code_err/err_cnt.
module pd_pluse_decoder #(
  parameter int TS_W       = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic [5:0]       code_in,
  input  logic             arm,
  input  logic             rd_en,
  output logic [TS_W+3:0]  rd_data,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [7:0]       evt_cnt
`ifdef PD_DECODE_ERR_EN
  ,
  output logic             code_err,
  output logic [7:0]       err_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = TS_W + 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_TRAIN = 2'd2
  } state_t;

  state_t state, state_n;

  logic [5:0] s1;
  logic [5:0] cs;
  logic [3:0] cp;   // {phase[2:0], start} of cs, one cycle older

  logic       ph_edge;
  logic [1:0] id_c;
  logic       d_ev;
  logic [1:0] d_id;
  logic       d_bb;
  logic       d_tetw;
  logic       d_rise;
  logic       d_fall;
`ifdef PD_DECODE_ERR_EN
  logic       multi_c;
  logic       d_multi;
  logic       err_ev;
`endif

  logic          arm_go;
  logic          start_train;
  logic          rec_ev;
  logic [TS_W-1:0] ts;

  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [RW-1:0] rd_hold;
  logic [RW-1:0] rec;
  logic          pop;
  logic          wr_ok;
  logic          drop;

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      s1 <= '0;
      cs <= '0;
      cp <= '0;
    end else begin
      s1 <= code_in;
      cs <= s1;
      cp <= {cs[4:2], cs[0]};
    end
  end

  always_comb begin
    ph_edge = (cp[3:1] == 3'b000) && (cs[4:2] != 3'b000);
    if (cs[2])
      id_c = 2'd1;
    else if (cs[3])
      id_c = 2'd2;
    else
      id_c = 2'd3;
  end

`ifdef PD_DECODE_ERR_EN
  assign multi_c = ((cs[4:2] & (cs[4:2] - 3'd1)) != 3'b000);
`endif

  // Registered decode stage: the FSM and FIFO act one cycle after the edge is seen.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      d_ev   <= 1'b0;
      d_id   <= 2'd0;
      d_bb   <= 1'b0;
      d_tetw <= 1'b0;
      d_rise <= 1'b0;
      d_fall <= 1'b0;
`ifdef PD_DECODE_ERR_EN
      d_multi <= 1'b0;
`endif
    end else begin
      d_ev   <= ph_edge;
      d_id   <= id_c;
      d_bb   <= cs[1];
      d_tetw <= cs[5];
      d_rise <= cs[0] & ~cp[0];
      d_fall <= ~cs[0] & cp[0];
`ifdef PD_DECODE_ERR_EN
      d_multi <= multi_c;
`endif
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n     = state;
    done        = 1'b0;
    arm_go      = 1'b0;
    start_train = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm) begin
          state_n = S_ARMED;
          arm_go  = 1'b1;
        end
      end
      S_ARMED: begin
        if (d_rise) begin
          state_n     = S_TRAIN;
          start_train = 1'b1;
        end
      end
      S_TRAIN: begin
        if (d_fall) begin
          state_n = S_IDLE;
          done    = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

`ifdef PD_DECODE_ERR_EN
  assign rec_ev = (state == S_TRAIN) && d_ev && !d_multi;
  assign err_ev = (state == S_TRAIN) && d_ev && d_multi;
`else
  assign rec_ev = (state == S_TRAIN) && d_ev;
`endif

  always_ff @(posedge clk_sys) begin
    if (!rst_n)
      ts <= '0;
    else if (arm_go || start_train)
      ts <= '0;
    else if ((state == S_TRAIN) && (ts != {TS_W{1'b1}}))
      ts <= ts + {{(TS_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n)
      evt_cnt <= 8'd0;
    else if (arm_go)
      evt_cnt <= 8'd0;
    else if (rec_ev && (evt_cnt != 8'hFF))
      evt_cnt <= evt_cnt + 8'd1;
  end

`ifdef PD_DECODE_ERR_EN
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      code_err <= 1'b0;
      err_cnt  <= 8'd0;
    end else if (arm_go) begin
      code_err <= 1'b0;
      err_cnt  <= 8'd0;
    end else if (err_ev) begin
      code_err <= 1'b1;
      if (err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

  // FIFO: pointers carry one wrap bit so full and empty are distinguishable.
  assign rec   = {d_id, d_bb, d_tetw, ts};
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = rd_en && !empty;
  assign wr_ok = rec_ev && (!full || pop);
  assign drop  = rec_ev && full && !pop;

  always_ff @(posedge clk_sys) begin
    if (wr_ok)
      mem[wptr[AW-1:0]] <= rec;
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_hold <= '0;
    end else begin
      if (wr_ok)
        wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop) begin
        rptr    <= rptr + {{AW{1'b0}}, 1'b1};
        rd_hold <= mem[rptr[AW-1:0]];
      end
    end
  end

  // Once drained, keep presenting the last record popped.
  assign rd_data = empty ? rd_hold : mem[rptr[AW-1:0]];

  always_ff @(posedge clk_sys) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (arm_go)
      overflow <= 1'b0;
    else if (drop)
      overflow <= 1'b1;
  end

endmodule
